// File: rtl/credit_on_off_tracker_pkg.sv
// Shared NoC types and sizing helpers for the credit on/off tracker.
package credit_on_off_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Keeps the VC index at least one bit wide when M == 1.
  function automatic int vc_idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/vc_credit_slot.sv
// One port/VC credit slot: counter, IDLE/ACTIVE/DRAIN FSM and sticky local error.
// NOC_ATOMIC_VC_EN: tail sends park the VC in DRAIN until every credit returns.
module vc_credit_slot
  import credit_on_off_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic send_i,
  input  logic tail_i,
  input  logic credit_i,
  output logic on_off_o,
  output logic vc_free_o,
  output logic error_o
);

  localparam int             CW   = cnt_width(DEPTH);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE  = CW'(1);

`ifdef NOC_ATOMIC_VC_EN
  localparam vc_state_t TAIL_STATE = DRAIN;
`else
  localparam vc_state_t TAIL_STATE = IDLE;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  vc_state_t     state_q, state_d;
  logic          err_q, err_d;
  logic          blocked;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_d   = cnt_q;
    state_d = state_q;
    err_d   = err_q;
    // A send with no credit left is dropped: counter and state stay put.
    blocked = send_i && !credit_i && (cnt_q == '0);

    if (send_i && !credit_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - ONE;
    end else if (credit_i && !send_i) begin
      if (cnt_q == FULL) err_d = 1'b1;
      else               cnt_d = cnt_q + ONE;
    end

    unique case (state_q)
      IDLE:   if (send_i && !blocked) state_d = tail_i ? TAIL_STATE : ACTIVE;
      ACTIVE: if (send_i && !blocked && tail_i) state_d = TAIL_STATE;
      DRAIN: begin
        if (send_i)              err_d   = 1'b1;
        else if (cnt_d == FULL)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state updates use non-blocking assignments so all slots see pre-edge values.
    if (reset) begin
      cnt_q   <= FULL;
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign on_off_o  = (cnt_q == '0);
  assign vc_free_o = (state_q == IDLE);
  assign error_o   = err_q;

endmodule

// File: rtl/credit_on_off_tracker.sv
// Per-port/VC credit tracker driving allocator on_off and vc_free; sticky error flag.
// NOC_ATOMIC_VC_EN selects atomic VC reallocation (see vc_credit_slot).
module credit_on_off_tracker
  import credit_on_off_tracker_pkg::*;
#(
  parameter int N     = 5,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N-1:0][M-1:0]                   flit_sent,
  input  logic [N-1:0]                          flit_tail,
  input  logic [N-1:0]                          credit_valid,
  input  logic [N-1:0][vc_idx_width(M)-1:0]     credit_vc,
  output logic [N-1:0][M-1:0]                   on_off,
  output logic [N-1:0][M-1:0]                   vc_free,
  output logic                                  error
);

  localparam int VCW = vc_idx_width(M);

  logic [N-1:0][M-1:0] slot_err;
  logic                multi_q, multi_d;

  for (genvar p = 0; p < N; p++) begin : g_port
    for (genvar v = 0; v < M; v++) begin : g_vc
      logic credit_hit;
      assign credit_hit = credit_valid[p] && (credit_vc[p] == VCW'(v));

      vc_credit_slot #(.DEPTH(DEPTH)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .send_i    (flit_sent[p][v]),
        .tail_i    (flit_tail[p]),
        .credit_i  (credit_hit),
        .on_off_o  (on_off[p][v]),
        .vc_free_o (vc_free[p][v]),
        .error_o   (slot_err[p][v])
      );
    end
  end

  // x & (x-1) is non-zero exactly when more than one VC on a port sends at once.
  always_comb begin
    multi_d = multi_q;
    for (int p = 0; p < N; p++) begin
      if ((flit_sent[p] & (flit_sent[p] - {{(M-1){1'b0}}, 1'b1})) != '0) multi_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) multi_q <= 1'b0;
    else       multi_q <= multi_d;
  end

  assign error = multi_q | (|slot_err);

endmodule

// File: tb/tb_credit_on_off_tracker.sv
// Scoreboard bench for credit_on_off_tracker (N=5, M=4, DEPTH=4), both VC modes.
module tb_credit_on_off_tracker;

`ifdef NOC_ATOMIC_VC_EN
  localparam bit ATOM = 1'b1;
`else
  localparam bit ATOM = 1'b0;
`endif

  localparam int K_ONOFF = 0, K_FREE = 1, K_ERR = 2, K_ONOFF_ALL = 3, K_FREE_ALL = 4;

  typedef struct {
    string       name;
    int          kind;
    int          p;
    int          v;
    logic [31:0] exp;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [4:0][3:0]  flit_sent;
  logic [4:0]       flit_tail;
  logic [4:0]       credit_valid;
  logic [4:0][1:0]  credit_vc;
  logic [4:0][3:0]  on_off;
  logic [4:0][3:0]  vc_free;
  logic             error;

  exp_t sb_q[$];
  event mon_ev;
  int   checks   = 0;
  int   failures = 0;

  credit_on_off_tracker #(.N(5), .M(4), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .flit_sent    (flit_sent),
    .flit_tail    (flit_tail),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .on_off       (on_off),
    .vc_free      (vc_free),
    .error        (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drains every queued expectation against the DUT outputs when signalled.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(mon_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          K_ONOFF:     got = 32'(on_off[e.p][e.v]);
          K_FREE:      got = 32'(vc_free[e.p][e.v]);
          K_ERR:       got = 32'(error);
          K_ONOFF_ALL: got = 32'(on_off);
          default:     got = 32'(vc_free);
        endcase
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s: got %0h expected %0h at %0t", e.name, got, e.exp, $time);
        end
      end
    end
  end

  task automatic expect_v(input string name, input int kind, input int p, input int v,
                          input logic [31:0] e);
    sb_q.push_back('{name, kind, p, v, e});
  endtask

  task automatic check_now();
    -> mon_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flit_sent    = '0;
    flit_tail    = '0;
    credit_valid = '0;
    credit_vc    = '0;
  endtask

  task automatic reset_values(input string tag);
    expect_v({tag, "_onoff_all"}, K_ONOFF_ALL, 0, 0, 32'h0);
    expect_v({tag, "_free_all"},  K_FREE_ALL,  0, 0, 32'hFFFFF);
    expect_v({tag, "_err"},       K_ERR,       0, 0, 32'h0);
  endtask

  initial begin
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_values("rst");
    check_now();
    reset = 1'b0;

    // p0/v1: four sends with no credits block the VC; one credit reopens it.
    flit_sent[0][1] = 1'b1;
    tick();
    expect_v("p0v1_head_free", K_FREE, 0, 1, 0);
    expect_v("p0v1_head_onoff", K_ONOFF, 0, 1, 0);
    check_now();
    tick();
    tick();
    expect_v("p0v1_cnt1_onoff", K_ONOFF, 0, 1, 0);
    check_now();
    flit_tail[0] = 1'b1;
    tick();
    expect_v("p0v1_cnt0_onoff", K_ONOFF, 0, 1, 1);
    expect_v("p0v1_tail_free", K_FREE, 0, 1, ATOM ? 0 : 1);
    check_now();
    clr();
    credit_valid[0] = 1'b1;
    credit_vc[0]    = 2'd1;
    tick();
    expect_v("p0v1_credit_onoff", K_ONOFF, 0, 1, 0);
    check_now();
    tick();
    tick();
    expect_v("p0v1_cnt3_free", K_FREE, 0, 1, ATOM ? 0 : 1);
    check_now();
    tick();
    expect_v("p0v1_cnt4_free", K_FREE, 0, 1, 1);
    expect_v("p0v1_err", K_ERR, 0, 0, 0);
    check_now();
    clr();

    // p2/v0: send and credit together at counter 2 leave the counter at 2.
    flit_sent[2][0] = 1'b1;
    tick();
    tick();
    expect_v("p2v0_cnt2_onoff", K_ONOFF, 2, 0, 0);
    check_now();
    credit_valid[2] = 1'b1;
    credit_vc[2]    = 2'd0;
    tick();
    expect_v("p2v0_both_onoff", K_ONOFF, 2, 0, 0);
    expect_v("p2v0_both_err", K_ERR, 0, 0, 0);
    check_now();
    credit_valid[2] = 1'b0;
    tick();
    expect_v("p2v0_cnt1_onoff", K_ONOFF, 2, 0, 0);
    check_now();
    flit_tail[2] = 1'b1;
    tick();
    expect_v("p2v0_cnt0_onoff", K_ONOFF, 2, 0, 1);
    expect_v("p2v0_tail_free", K_FREE, 2, 0, ATOM ? 0 : 1);
    check_now();
    clr();
    credit_valid[2] = 1'b1;
    repeat (4) tick();
    expect_v("p2v0_refill_onoff", K_ONOFF, 2, 0, 0);
    expect_v("p2v0_refill_free", K_FREE, 2, 0, 1);
    expect_v("p2v0_refill_err", K_ERR, 0, 0, 0);
    check_now();
    clr();

    // p1/v3: head, body, tail; VC reusable after the tail or after the last credit.
    flit_sent[1][3] = 1'b1;
    tick();
    expect_v("p1v3_head_free", K_FREE, 1, 3, 0);
    check_now();
    tick();
    flit_tail[1] = 1'b1;
    tick();
    expect_v("p1v3_tail_free", K_FREE, 1, 3, ATOM ? 0 : 1);
    check_now();
    clr();
    credit_valid[1] = 1'b1;
    credit_vc[1]    = 2'd3;
    tick();
    expect_v("p1v3_cr1_free", K_FREE, 1, 3, ATOM ? 0 : 1);
    check_now();
    tick();
    expect_v("p1v3_cr2_free", K_FREE, 1, 3, ATOM ? 0 : 1);
    check_now();
    tick();
    expect_v("p1v3_cr3_free", K_FREE, 1, 3, 1);
    expect_v("p1v3_err", K_ERR, 0, 0, 0);
    check_now();
    clr();

    // p4/v2: send at counter 0 is dropped, credit at full saturates; error sticks.
    flit_sent[4][2] = 1'b1;
    repeat (3) tick();
    flit_tail[4] = 1'b1;
    tick();
    expect_v("p4v2_cnt0_onoff", K_ONOFF, 4, 2, 1);
    expect_v("p4v2_cnt0_err", K_ERR, 0, 0, 0);
    check_now();
    flit_tail[4] = 1'b0;
    tick();
    expect_v("p4v2_under_err", K_ERR, 0, 0, 1);
    expect_v("p4v2_under_onoff", K_ONOFF, 4, 2, 1);
    expect_v("p4v2_under_free", K_FREE, 4, 2, ATOM ? 0 : 1);
    check_now();
    clr();
    credit_valid[4] = 1'b1;
    credit_vc[4]    = 2'd2;
    repeat (4) tick();
    expect_v("p4v2_full_onoff", K_ONOFF, 4, 2, 0);
    expect_v("p4v2_full_free", K_FREE, 4, 2, 1);
    check_now();
    tick();
    expect_v("p4v2_over_err", K_ERR, 0, 0, 1);
    check_now();
    clr();
    flit_sent[4][2] = 1'b1;
    repeat (3) tick();
    expect_v("p4v2_sat_cnt1_onoff", K_ONOFF, 4, 2, 0);
    check_now();
    tick();
    expect_v("p4v2_sat_cnt0_onoff", K_ONOFF, 4, 2, 1);
    expect_v("p4v2_err_held", K_ERR, 0, 0, 1);
    check_now();
    clr();

    // Reset mid-packet: p1/v0 at counter 1, p0/v0 at counter 0.
    flit_sent[1][0] = 1'b1;
    flit_sent[0][0] = 1'b1;
    repeat (3) tick();
    flit_sent[1][0] = 1'b0;
    tick();
    expect_v("pre_rst_p0v0_onoff", K_ONOFF, 0, 0, 1);
    expect_v("pre_rst_p1v0_onoff", K_ONOFF, 1, 0, 0);
    expect_v("pre_rst_p1v0_free", K_FREE, 1, 0, 0);
    check_now();
    clr();
    reset = 1'b1;
    #1;
    reset_values("async_rst");
    check_now();
    tick();
    reset = 1'b0;
    flit_sent[1][0] = 1'b1;
    tick();
    expect_v("post_rst_p1v0_free", K_FREE, 1, 0, 0);
    expect_v("post_rst_p1v0_onoff", K_ONOFF, 1, 0, 0);
    expect_v("post_rst_p0v0_onoff", K_ONOFF, 0, 0, 0);
    expect_v("post_rst_err", K_ERR, 0, 0, 0);
    check_now();
    clr();

    // p3: two VCs sent on one port in one cycle, each still processed.
    flit_sent[3][0] = 1'b1;
    flit_sent[3][2] = 1'b1;
    flit_tail[3]    = 1'b1;
    tick();
    expect_v("multi_err", K_ERR, 0, 0, 1);
    expect_v("multi_v0_free", K_FREE, 3, 0, ATOM ? 0 : 1);
    expect_v("multi_v2_free", K_FREE, 3, 2, ATOM ? 0 : 1);
    expect_v("multi_v1_free", K_FREE, 3, 1, 1);
    check_now();
    clr();

    #2;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/credit_on_off_tracker.md
CREDIT_ON_OFF_TRACKER -- requirements
Module: credit_on_off_tracker

Interface
REQ-001 SHALL have parameter N, default 5, number of router output ports.
REQ-002 SHALL have parameter M, default 4, virtual channels per port.
REQ-003 SHALL have parameter DEPTH, default 4, downstream buffer slots per VC (range 1..15).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flit_sent, input, [N][M], flit forwarded downstream on port/VC this cycle.
REQ-007 SHALL have port flit_tail, input, [N], flit sent on that port this cycle is a tail (or head-tail).
REQ-008 SHALL have port credit_valid, input, [N], downstream freed one slot.
REQ-009 SHALL have port credit_vc, input, [N][$clog2(M)], VC of the returned credit.
REQ-010 SHALL have port on_off, output, [N][M], 1 = VC blocked; feeds allocator on_off.
REQ-011 SHALL have port vc_free, output, [N][M], 1 = VC allocatable to a new packet.
REQ-012 SHALL have port error, output, 1, sticky protocol-violation flag.

Function
REQ-013 SHALL keep a credit counter per [port][VC], width $clog2(DEPTH+1).
REQ-014 SHALL decrement the counter on flit_sent and increment it on matching credit_valid/credit_vc; both events together in one cycle SHALL leave it unchanged.
REQ-015 SHALL drive on_off[p][v] = (counter == 0), from registered state only, with no combinational input-to-output path.
REQ-016 SHALL run a per-VC FSM: IDLE, ACTIVE, DRAIN.
REQ-017 SHALL go IDLE->ACTIVE on flit_sent with flit_tail=0.
REQ-018 SHALL go ACTIVE->DRAIN on flit_sent with flit_tail=1.
REQ-019 SHALL go IDLE->DRAIN on flit_sent with flit_tail=1 (single-flit packet).
REQ-020 SHALL go DRAIN->IDLE in the cycle the counter becomes DEPTH, or when DEPTH is already held and no send occurs.
REQ-021 SHALL drive vc_free[p][v] = (state == IDLE), registered.
REQ-022 SHALL, on flit_sent at counter 0, hold the counter at 0, leave the state unchanged and set error.
REQ-023 SHALL, on credit return at counter DEPTH, saturate at DEPTH and set error.
REQ-024 SHALL, on more than one flit_sent bit set on a port in one cycle, process each bit independently and set error.
REQ-025 SHALL, on flit_sent to a VC in DRAIN, decrement the counter, keep DRAIN and set error.
REQ-026 SHALL, once set, hold error until reset.

Reset
REQ-027 SHALL, on reset assertion mid-operation, immediately force counters to DEPTH, states to IDLE, on_off to all-0, vc_free to all-1 and error to 0.
REQ-028 SHALL, on the first edge after reset deassertion, process inputs normally.

Configuration
REQ-029 SHALL use macro NOC_ATOMIC_VC_EN.
REQ-030 SHALL, with NOC_ATOMIC_VC_EN defined, apply REQ-018..020 exactly: the VC is reallocated only after all credits return.
REQ-031 SHALL, without NOC_ATOMIC_VC_EN, make tail sends go directly to IDLE, never enter DRAIN, and not apply REQ-025.

Structure
REQ-032 SHALL place the vc_state_t enum (IDLE, ACTIVE, DRAIN) and the credit counter width function in the shared NoC package.
REQ-033 SHALL instantiate one sub-module vc_credit_slot per [port][VC], holding the counter, FSM and local error; the top level decodes credit_vc and OR-reduces error.

Verification
REQ-034 SHALL test: DEPTH=4, 4 sends on p0/v1 with no credits -> on_off[0][1]=1 the next cycle; 1 credit -> on_off 0 the next cycle.
REQ-035 SHALL test: send plus credit on p2/v0 in the same cycle at counter 2 -> counter stays 2, on_off unchanged, no error.
REQ-036 SHALL test: head, body, tail on p1/v3 with atomic mode -> vc_free 0 after head and still 0 after tail until the 3rd credit returns; vc_free=1 the cycle after.
REQ-037 SHALL test: same sequence without NOC_ATOMIC_VC_EN -> vc_free=1 the cycle after the tail.
REQ-038 SHALL test: send at counter 0, then a credit at counter DEPTH -> error=1 and held; counters saturate at 0 and 4.
REQ-039 SHALL test: reset asserted mid-packet with counter 1 -> outputs at reset values asynchronously, before the next clock edge.
